// File: rtl/rv_pkg.sv
// rv: shared RV32 front-end types and constants
//   fetch_entry_t : {pc, instr} pair carried from fetch to decode
//   RV32_NOP      : canonical addi x0, x0, 0 encoding
package rv;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    localparam logic [31:0] RV32_NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous in-order FIFO of fetch entries
//   push/wdata : write an entry (accepted when not full, or full with a same-cycle pop)
//   pop/rdata  : rdata is the head entry; pop removes it when not empty
//   flush      : empties the FIFO, overriding push and pop
//   full/empty/count : occupancy status
module fetch_fifo
    import rv::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, instruction memory requests and decode-side queue
//   imem_req_*  : word-aligned read requests, valid/ready
//   imem_rsp_*  : in-order read responses, no backpressure
//   redirect_*  : one-cycle PC redirect from execute; flushes queue and in-flight work
//   instr_*     : {instruction, instr_pc} to decode, valid/ready
module fetch_unit
    import rv::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc;
    logic [CW-1:0] outstanding, discard, out_nxt, q_count, p_count;
    logic [CW:0]   in_use;
    fetch_entry_t  q_head, p_head, q_wdata, p_wdata;
    logic          q_full, q_empty, p_full, p_empty;
    logic          req_fire, rsp_keep, rsp_ret;
    logic          unused_ok;

    // Outstanding requests plus queued entries never exceed DEPTH, so every
    // returning word has a guaranteed queue slot.
    assign in_use         = {1'b0, outstanding} + {1'b0, q_count};
    assign imem_req_valid = !redirect_valid && in_use < (CW+1)'(DEPTH);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_ret        = imem_rsp_valid && outstanding != '0;
    // A response arriving in the redirect cycle is stale and dropped here.
    assign rsp_keep       = imem_rsp_valid && discard == '0 && !redirect_valid;
    assign out_nxt        = outstanding + CW'(req_fire) - CW'(rsp_ret);

    assign p_wdata     = {pc, 32'h0};
    assign q_wdata     = {p_head.pc, imem_rsp_data};
    assign instr_valid = !q_empty;
    assign instruction = q_head.instr;
    assign instr_pc    = q_head.pc;
    assign unused_ok   = ^{p_head.instr, p_full, p_empty, p_count, q_full, redirect_pc[1:0]};

    // Tracks PCs of live requests; discarded responses never pop it because
    // it was flushed together with the queue.
    fetch_fifo #(.DEPTH(DEPTH)) u_pend (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_fire),
        .pop   (rsp_keep),
        .flush (redirect_valid),
        .wdata (p_wdata),
        .rdata (p_head),
        .full  (p_full),
        .empty (p_empty),
        .count (p_count)
    );

    fetch_fifo #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_keep),
        .pop   (instr_valid && instr_ready),
        .flush (redirect_valid),
        .wdata (q_wdata),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= out_nxt > CW'(DEPTH) ? CW'(DEPTH) : out_nxt;
            if (redirect_valid) begin
                pc      <= {redirect_pc[31:2], 2'b00};
                discard <= outstanding - CW'(rsp_ret);
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                if (imem_rsp_valid && discard != '0) discard <= discard - CW'(1);
            end
        end
    end
endmodule
